// File: rtl/key_extract_mt.sv
// key_extract_mt: per-tenant match-key extractor; table read (S1), container select (S2), compare into registered outputs.
// Define KEY_EXTRACT_MT_CFG_RD_EN to add the table readback port.
module key_extract_mt #(
   parameter int STAGE_ID = 0,
   parameter int C6_NUM   = 8,
   parameter int C4_NUM   = 8,
   parameter int C2_NUM   = 8,
   parameter int IDX_W    = 3,
   parameter int META_LEN = 256,
   parameter int PHV_LEN  = 48*C6_NUM+32*C4_NUM+16*C2_NUM+META_LEN,
   parameter int VID_W    = 4,
   parameter int VID_LSB  = 140,
   parameter int KEY_LEN  = 2*48+2*32+2*16+1,
   parameter int ENTRY_W  = 6*IDX_W+2+2*(IDX_W+6)+1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PHV_LEN-1:0] phv_in,
   input  logic               phv_valid_in,
   output logic               phv_ready_out,
   output logic [PHV_LEN-1:0] phv_out,
   output logic [KEY_LEN-1:0] key_out,
   output logic               key_hit_out,
   output logic               out_valid,
   input  logic               out_ready,
   input  logic               cfg_wr_en,
   input  logic [VID_W-1:0]   cfg_wr_addr,
   input  logic [ENTRY_W-1:0] cfg_wr_data
`ifdef KEY_EXTRACT_MT_CFG_RD_EN
   ,
   input  logic               cfg_rd_en,
   input  logic [VID_W-1:0]   cfg_rd_addr,
   output logic [ENTRY_W-1:0] cfg_rd_data,
   output logic               cfg_rd_valid
`endif
);
   localparam int OP_W   = IDX_W+6;
   localparam int C2_LSB = META_LEN;
   localparam int C4_LSB = C2_LSB+16*C2_NUM;
   localparam int C6_LSB = C4_LSB+32*C4_NUM;
   localparam int K_LSB  = 2*OP_W+2;

   // immediates live in operand bits [7:0], below the imm flag at IDX_W+5
   if (IDX_W < 3 || STAGE_ID < 0) begin : g_param_check
      $error("key_extract_mt: IDX_W must be at least 3 and STAGE_ID non-negative");
   end

   function automatic logic [47:0] sel6(input logic [PHV_LEN-1:0] p, input logic [IDX_W-1:0] i);
      return int'(i) < C6_NUM ? p[C6_LSB+48*int'(i) +: 48] : 48'd0;
   endfunction

   function automatic logic [31:0] sel4(input logic [PHV_LEN-1:0] p, input logic [IDX_W-1:0] i);
      return int'(i) < C4_NUM ? p[C4_LSB+32*int'(i) +: 32] : 32'd0;
   endfunction

   function automatic logic [15:0] sel2(input logic [PHV_LEN-1:0] p, input logic [IDX_W-1:0] i);
      return int'(i) < C2_NUM ? p[C2_LSB+16*int'(i) +: 16] : 16'd0;
   endfunction

   function automatic logic [7:0] opnd(input logic [PHV_LEN-1:0] p, input logic [OP_W-1:0] o);
      logic [47:0] v6;
      logic [31:0] v4;
      logic [15:0] v2;
      logic [1:0]  t;
      v6 = sel6(p, o[IDX_W-1:0]);
      v4 = sel4(p, o[IDX_W-1:0]);
      v2 = sel2(p, o[IDX_W-1:0]);
      t  = o[IDX_W+1:IDX_W];
      return o[OP_W-1] ? o[7:0] : t == 2'b10 ? v6[7:0] : t == 2'b01 ? v4[7:0] : t == 2'b00 ? v2[7:0] : 8'd0;
   endfunction

   logic [ENTRY_W-1:0] tbl [2**VID_W];
   logic               stall;
   logic               s1_valid, s2_valid, s2_hit, pred;
   logic [PHV_LEN-1:0] s1_phv, s2_phv;
   logic [ENTRY_W-1:0] s1_entry;
   logic [1:0]         s2_op;
   logic [7:0]         s2_a, s2_b;
   logic [KEY_LEN-2:0] s2_key;
   logic [IDX_W-1:0]   k6a, k6b, k4a, k4b, k2a, k2b;

   assign stall         = out_valid & ~out_ready;
   assign phv_ready_out = ~stall;

   assign k6a = s1_entry[K_LSB+5*IDX_W +: IDX_W];
   assign k6b = s1_entry[K_LSB+4*IDX_W +: IDX_W];
   assign k4a = s1_entry[K_LSB+3*IDX_W +: IDX_W];
   assign k4b = s1_entry[K_LSB+2*IDX_W +: IDX_W];
   assign k2a = s1_entry[K_LSB+IDX_W +: IDX_W];
   assign k2b = s1_entry[K_LSB +: IDX_W];

   assign pred = s2_op == 2'b00 ? s2_a > s2_b : s2_op == 2'b01 ? s2_a >= s2_b : s2_op == 2'b10 ? s2_a == s2_b : 1'b1;

   // table writes ignore stall; a same-edge S1 capture still reads the old entry
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int j = 0; j < 2**VID_W; j++) tbl[j] <= '0;
      else if (cfg_wr_en)
         tbl[cfg_wr_addr] <= cfg_wr_data;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_phv   <= '0;
         s1_entry <= '0;
      end else if (!stall) begin
         s1_valid <= phv_valid_in;
         s1_phv   <= phv_in;
         s1_entry <= tbl[phv_in[VID_LSB +: VID_W]];
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_phv   <= '0;
         s2_hit   <= 1'b0;
         s2_op    <= '0;
         s2_a     <= '0;
         s2_b     <= '0;
         s2_key   <= '0;
      end else if (!stall) begin
         s2_valid <= s1_valid;
         s2_phv   <= s1_phv;
         s2_hit   <= s1_entry[ENTRY_W-1];
         s2_op    <= s1_entry[K_LSB-1 -: 2];
         s2_a     <= opnd(s1_phv, s1_entry[OP_W +: OP_W]);
         s2_b     <= opnd(s1_phv, s1_entry[0 +: OP_W]);
         s2_key   <= {sel6(s1_phv, k6a), sel6(s1_phv, k6b), sel4(s1_phv, k4a), sel4(s1_phv, k4b),
                      sel2(s1_phv, k2a), sel2(s1_phv, k2b)};
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid   <= 1'b0;
         phv_out     <= '0;
         key_out     <= '0;
         key_hit_out <= 1'b0;
      end else if (!stall) begin
         out_valid   <= s2_valid;
         phv_out     <= s2_phv;
         key_out     <= s2_hit ? {s2_key, pred} : '0;
         key_hit_out <= s2_hit;
      end

`ifdef KEY_EXTRACT_MT_CFG_RD_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cfg_rd_data  <= '0;
         cfg_rd_valid <= 1'b0;
      end else begin
         cfg_rd_valid <= cfg_rd_en;
         if (cfg_rd_en) cfg_rd_data <= tbl[cfg_rd_addr];
      end
`endif
endmodule

// File: tb/tb_key_extract_mt.sv
// tb_key_extract_mt: scoreboard bench for key_extract_mt; readback checks run when KEY_EXTRACT_MT_CFG_RD_EN is defined.
module tb_key_extract_mt;
   localparam int PHV_LEN = 1024;
   localparam int KEY_LEN = 193;
   localparam int ENTRY_W = 39;

   typedef struct {
      logic [PHV_LEN-1:0] phv;
      logic [KEY_LEN-1:0] key;
      logic               hit;
   } exp_t;

   logic               clk, rst_n;
   logic [PHV_LEN-1:0] phv_in, phv_out;
   logic               phv_valid_in, phv_ready_out;
   logic [KEY_LEN-1:0] key_out;
   logic               key_hit_out, out_valid, out_ready;
   logic               cfg_wr_en;
   logic [3:0]         cfg_wr_addr;
   logic [ENTRY_W-1:0] cfg_wr_data;
`ifdef KEY_EXTRACT_MT_CFG_RD_EN
   logic               cfg_rd_en, cfg_rd_valid;
   logic [3:0]         cfg_rd_addr;
   logic [ENTRY_W-1:0] cfg_rd_data;
`endif

   key_extract_mt dut (
      .clk(clk), .rst_n(rst_n),
      .phv_in(phv_in), .phv_valid_in(phv_valid_in), .phv_ready_out(phv_ready_out),
      .phv_out(phv_out), .key_out(key_out), .key_hit_out(key_hit_out),
      .out_valid(out_valid), .out_ready(out_ready),
      .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data)
`ifdef KEY_EXTRACT_MT_CFG_RD_EN
      , .cfg_rd_en(cfg_rd_en), .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data), .cfg_rd_valid(cfg_rd_valid)
`endif
   );

   logic [47:0]        c6 [8];
   logic [31:0]        c4 [8];
   logic [15:0]        c2 [8];
   logic [255:0]       meta;
   logic [ENTRY_W-1:0] tbl_m [16];
   exp_t               sb [$];
   int                 checks, failures, delivered;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [ENTRY_W-1:0] mk(input logic v, input logic [2:0] a6, b6, a4, b4, a2, b2,
                                             input logic [1:0] op, input logic [8:0] a, b);
      return {v, a6, b6, a4, b4, a2, b2, op, a, b};
   endfunction

   function automatic logic [8:0] imm(input logic [7:0] x);
      return {1'b1, x};
   endfunction

   function automatic logic [8:0] src(input logic [1:0] t, input logic [2:0] i);
      return {4'b0000, t, i};
   endfunction

   function automatic logic [7:0] m_opnd(input logic [8:0] o);
      if (o[8]) return o[7:0];
      case (o[4:3])
         2'b10:   return c6[o[2:0]][7:0];
         2'b01:   return c4[o[2:0]][7:0];
         2'b00:   return c2[o[2:0]][7:0];
         default: return 8'd0;
      endcase
   endfunction

   function automatic logic [KEY_LEN:0] m_key(input logic [ENTRY_W-1:0] e);
      logic [7:0] a, b;
      logic       p;
      if (!e[38]) return '0;
      a = m_opnd(e[17:9]);
      b = m_opnd(e[8:0]);
      case (e[19:18])
         2'b00:   p = a > b;
         2'b01:   p = a >= b;
         2'b10:   p = a == b;
         default: p = 1'b1;
      endcase
      return {1'b1, c6[e[37:35]], c6[e[34:32]], c4[e[31:29]], c4[e[28:26]], c2[e[25:23]], c2[e[22:20]], p};
   endfunction

   function automatic logic [PHV_LEN-1:0] m_phv(input logic [3:0] vid);
      logic [255:0] m;
      m = meta;
      m[143:140] = vid;
      return {c6[7], c6[6], c6[5], c6[4], c6[3], c6[2], c6[1], c6[0],
              c4[7], c4[6], c4[5], c4[4], c4[3], c4[2], c4[1], c4[0],
              c2[7], c2[6], c2[5], c2[4], c2[3], c2[2], c2[1], c2[0], m};
   endfunction

   task automatic rand_fields;
      for (int i = 0; i < 8; i++) begin
         c6[i] = 48'({$urandom(), $urandom()});
         c4[i] = $urandom();
         c2[i] = 16'($urandom());
         meta[i*32 +: 32] = $urandom();
      end
   endtask

   // drives one cycle from a negedge; expected results are pushed using the pre-write table model
   task automatic drive(input logic v, input logic [3:0] vid, input logic we, input logic [3:0] wa,
                        input logic [ENTRY_W-1:0] wd, output logic acc);
      logic [KEY_LEN:0] hk;
      phv_valid_in = v;
      phv_in       = m_phv(vid);
      cfg_wr_en    = we;
      cfg_wr_addr  = wa;
      cfg_wr_data  = wd;
      #1;
      acc = v && phv_ready_out;
      if (acc) begin
         hk = m_key(tbl_m[vid]);
         sb.push_back('{phv_in, hk[KEY_LEN-1:0], hk[KEY_LEN]});
      end
      @(posedge clk);
      #1;
      phv_valid_in = 1'b0;
      cfg_wr_en    = 1'b0;
      if (we) tbl_m[wa] = wd;
      @(negedge clk);
   endtask

   task automatic wait_out(output logic got);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (out_valid) got = 1'b1;
         else @(negedge clk);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      #1;
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_spurious: out_valid=1 key=%h with no pending PHV", key_out);
         end else begin
            e = sb.pop_front();
            delivered++;
            if (phv_out !== e.phv || key_out !== e.key || key_hit_out !== e.hit) begin
               failures++;
               $display("FAIL scoreboard: got key=%h hit=%b phv_match=%0b, expected key=%h hit=%b",
                        key_out, key_hit_out, phv_out === e.phv, e.key, e.hit);
            end
         end
      end
   end

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++;
      if (key_out !== '0 || key_hit_out !== 1'b0) begin
         failures++; $display("FAIL reset_key: got key=%h hit=%b want 0/0", key_out, key_hit_out);
      end
      checks++;
      if (phv_out !== '0) begin failures++; $display("FAIL reset_phv_out: got nonzero want 0"); end
      checks++;
      if (phv_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", phv_ready_out); end
`ifdef KEY_EXTRACT_MT_CFG_RD_EN
      checks++;
      if (cfg_rd_valid !== 1'b0 || cfg_rd_data !== '0) begin
         failures++; $display("FAIL reset_rd: got valid=%b data=%h want 0/0", cfg_rd_valid, cfg_rd_data);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_traffic;
      logic acc;
      logic [PHV_LEN-1:0] sent;
      rand_fields;
      drive(1'b1, 4'd3, 1'b0, 4'd0, '0, acc);
      sent = phv_in;
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early: out_valid=%b after 1 edge, want 0", out_valid); end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL latency_n2: out_valid=%b after 2 edges, want 1", out_valid); end
      checks++;
      if (key_out !== '0 || key_hit_out !== 1'b0 || phv_out !== sent) begin
         failures++; $display("FAIL empty_table: got key=%h hit=%b phv_match=%0b want 0/0/1", key_out, key_hit_out, phv_out === sent);
      end
      @(negedge clk);
   endtask

   task automatic test_basic_extract;
      logic acc, got;
      logic [KEY_LEN-1:0] want;
      drive(1'b0, 4'd0, 1'b1, 4'd5, mk(1'b1, 3'd7, 3'd0, 3'd2, 3'd3, 3'd1, 3'd6, 2'b10, imm(8'h2A), src(2'b00, 3'd1)), acc);
      rand_fields;
      c2[1][7:0] = 8'h2A;
      want = {c6[7], c6[0], c4[2], c4[3], c2[1], c2[6], 1'b1};
      drive(1'b1, 4'd5, 1'b0, 4'd0, '0, acc);
      wait_out(got);
      checks++;
      if (!got || key_out !== want || key_hit_out !== 1'b1) begin
         failures++; $display("FAIL basic_extract: got valid=%b key=%h hit=%b want key=%h hit=1", got, key_out, key_hit_out, want);
      end
      @(negedge clk);
      rand_fields;
      c2[1][7:0] = 8'h2B;
      drive(1'b1, 4'd5, 1'b0, 4'd0, '0, acc);
      wait_out(got);
      checks++;
      if (!got || key_out[0] !== 1'b0) begin
         failures++; $display("FAIL basic_pred_ne: got valid=%b pred=%b want 1/0", got, key_out[0]);
      end
      @(negedge clk);
   endtask

   task automatic test_comparators;
      logic acc, got;
      logic [ENTRY_W-1:0] ents [6];
      logic want [6];
      ents[0] = mk(1'b1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 2'b00, src(2'b01, 3'd0), imm(8'h10)); want[0] = 1'b0;
      ents[1] = mk(1'b1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 2'b01, src(2'b01, 3'd0), imm(8'h10)); want[1] = 1'b1;
      ents[2] = mk(1'b1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 2'b11, src(2'b01, 3'd0), imm(8'h10)); want[2] = 1'b1;
      ents[3] = mk(1'b1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 2'b10, src(2'b11, 3'd5), imm(8'h00)); want[3] = 1'b1;
      ents[4] = mk(1'b1, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00, src(2'b10, 3'd7), imm(8'h7F)); want[4] = 1'b1;
      ents[5] = mk(1'b1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 2'b10, src(2'b01, 3'd0), imm(8'h11)); want[5] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 4'd0, 1'b1, 4'd6, ents[k], acc);
         rand_fields;
         c4[0][7:0] = 8'h10;
         c6[7][7:0] = 8'h80;
         drive(1'b1, 4'd6, 1'b0, 4'd0, '0, acc);
         wait_out(got);
         checks++;
         if (!got || key_out[0] !== want[k]) begin
            failures++; $display("FAIL comparator_%0d: got valid=%b pred=%b want 1/%b", k, got, key_out[0], want[k]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_write_collision;
      logic acc, got;
      rand_fields;
      drive(1'b1, 4'd2, 1'b1, 4'd2, mk(1'b1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 2'b11, imm(8'h0), imm(8'h0)), acc);
      rand_fields;
      drive(1'b1, 4'd2, 1'b0, 4'd0, '0, acc);
      wait_out(got);
      checks++;
      if (!got || key_hit_out !== 1'b0) begin
         failures++; $display("FAIL collision_old: got valid=%b hit=%b want 1/0", got, key_hit_out);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || key_hit_out !== 1'b1) begin
         failures++; $display("FAIL collision_new: got valid=%b hit=%b want 1/1", out_valid, key_hit_out);
      end
      @(negedge clk);
      drive(1'b0, 4'd0, 1'b1, 4'd9, mk(1'b1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 2'b11, imm(8'h0), imm(8'h0)), acc);
      drive(1'b0, 4'd0, 1'b1, 4'd9, '0, acc);
      rand_fields;
      drive(1'b1, 4'd9, 1'b0, 4'd0, '0, acc);
      wait_out(got);
      checks++;
      if (!got || key_hit_out !== 1'b0 || key_out !== '0) begin
         failures++; $display("FAIL last_write_wins: got valid=%b hit=%b key=%h want 1/0/0", got, key_hit_out, key_out);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic acc, stalled;
      logic [3:0] vid;
      logic [PHV_LEN-1:0] sp;
      logic [KEY_LEN-1:0] sk;
      logic sh;
      int sent, base, nstall;
      sent = 0; nstall = 0; stalled = 1'b0; sp = '0; sk = '0; sh = 1'b0;
      base = delivered;
      rand_fields;
      vid = 4'($urandom_range(0, 15));
      for (int c = 0; c < 12; c++) begin
         out_ready = !(c >= 3 && c <= 5);
         #1;
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || phv_out !== sp || key_out !== sk || key_hit_out !== sh) begin
               failures++; $display("FAIL stall_hold_c%0d: got valid=%b key=%h hit=%b want held key=%h hit=%b", c, out_valid, key_out, key_hit_out, sk, sh);
            end
         end
         stalled = out_valid && !out_ready;
         if (stalled) begin
            nstall++;
            checks++;
            if (phv_ready_out !== 1'b0) begin failures++; $display("FAIL stall_ready_c%0d: got %b want 0", c, phv_ready_out); end
            sp = phv_out; sk = key_out; sh = key_hit_out;
         end
         drive(sent < 6, vid, 1'b0, 4'd0, '0, acc);
         if (acc) begin
            sent++;
            rand_fields;
            vid = 4'($urandom_range(0, 15));
         end
      end
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (nstall != 3) begin failures++; $display("FAIL stall_cycles: got %0d want 3", nstall); end
      checks++;
      if (sent != 6 || delivered - base != 6) begin
         failures++; $display("FAIL stream_count: sent=%0d delivered=%0d want 6/6", sent, delivered - base);
      end
   endtask

   task automatic test_midflight_reset;
      logic acc, got, quiet;
      for (int k = 0; k < 3; k++) begin
         rand_fields;
         drive(1'b1, 4'd5, 1'b0, 4'd0, '0, acc);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || key_out !== '0 || key_hit_out !== 1'b0 || phv_out !== '0) begin
         failures++; $display("FAIL async_reset: got valid=%b hit=%b want 0/0", out_valid, key_hit_out);
      end
      sb.delete();
      for (int k = 0; k < 16; k++) tbl_m[k] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (out_valid !== 1'b0) quiet = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (!quiet) begin failures++; $display("FAIL reset_drop: out_valid reasserted for dropped PHVs"); end
      rand_fields;
      drive(1'b1, 4'd5, 1'b0, 4'd0, '0, acc);
      wait_out(got);
      checks++;
      if (!got || key_hit_out !== 1'b0) begin
         failures++; $display("FAIL table_cleared: got valid=%b hit=%b want 1/0", got, key_hit_out);
      end
      @(negedge clk);
`ifdef KEY_EXTRACT_MT_CFG_RD_EN
      cfg_rd_en = 1'b1; cfg_rd_addr = 4'd5;
      @(posedge clk);
      #1;
      cfg_rd_en = 1'b0;
      checks++;
      if (cfg_rd_valid !== 1'b1 || cfg_rd_data !== '0) begin
         failures++; $display("FAIL rd_after_reset: got valid=%b data=%h want 1/0", cfg_rd_valid, cfg_rd_data);
      end
      @(negedge clk);
      #1;
      checks++;
      if (cfg_rd_valid !== 1'b0) begin failures++; $display("FAIL rd_pulse: got %b want 0", cfg_rd_valid); end
      @(negedge clk);
      cfg_rd_en = 1'b1; cfg_rd_addr = 4'd4;
      cfg_wr_en = 1'b1; cfg_wr_addr = 4'd4; cfg_wr_data = 39'h5A_5A5A_5A5A;
      @(posedge clk);
      #1;
      cfg_wr_en = 1'b0;
      checks++;
      if (cfg_rd_data !== '0) begin failures++; $display("FAIL rd_collision: got %h want 0", cfg_rd_data); end
      @(posedge clk);
      #1;
      cfg_rd_en = 1'b0;
      checks++;
      if (cfg_rd_valid !== 1'b1 || cfg_rd_data !== 39'h5A_5A5A_5A5A) begin
         failures++; $display("FAIL rd_new: got valid=%b data=%h want 1/5a5a5a5a5a", cfg_rd_valid, cfg_rd_data);
      end
      tbl_m[4] = 39'h5A_5A5A_5A5A;
      @(negedge clk);
`endif
   endtask

   initial begin
      checks = 0; failures = 0; delivered = 0;
      phv_in = '0; phv_valid_in = 1'b0; out_ready = 1'b1;
      cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
`ifdef KEY_EXTRACT_MT_CFG_RD_EN
      cfg_rd_en = 1'b0; cfg_rd_addr = '0;
`endif
      for (int k = 0; k < 16; k++) tbl_m[k] = '0;
      meta = '0;
      @(negedge clk);
      test_reset;
      test_traffic;
      test_basic_extract;
      test_comparators;
      test_write_collision;
      test_back_to_back;
      test_midflight_reset;
      repeat (4) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: %0d PHVs never delivered, want 0", sb.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
